// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: PC, word-addressed instruction memory and the
// IF/ID register feeding decode, with stall, redirect and a program-load port.
module inst_fetch #(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STALL,
  input  logic               REDIRECT,
  input  logic [31:0]        REDIRECT_PC,
  input  logic               IMEM_WE,
  input  logic [IMEM_AW-1:0] IMEM_WADDR,
  input  logic [31:0]        IMEM_WDATA,
  output logic [31:0]        Ins,
  output logic [31:0]        PC_OUT,
  output logic [31:0]        PC4_OUT,
  output logic               VALID,
  output logic               ERR,
  output logic [31:0]        FETCH_CNT
);

  logic [31:0] mem_q [0:(1<<IMEM_AW)-1];

  logic [31:0] pc_f_q,   pc_f_d;
  logic [31:0] ins_q,    ins_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q,  valid_d;
  logic        err_q,    err_d;
  logic [31:0] cnt_q,    cnt_d;

  logic [IMEM_AW-1:0] rd_idx;
  logic [31:0]        fetch_word;

  // Upper PC bits alias, so the fetch address wraps modulo the memory size.
  assign rd_idx     = pc_f_q[IMEM_AW+1:2];
  assign fetch_word = mem_q[rd_idx];

  // Writes ignore reset/stall/redirect so a program can be loaded under reset;
  // the combinational read above sees the pre-edge word (read-before-write).
  always_ff @(posedge CLK) begin
    if (IMEM_WE) mem_q[IMEM_WADDR] <= IMEM_WDATA;
  end

  always_comb begin
    pc_f_d   = pc_f_q;
    ins_d    = ins_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (REDIRECT) begin
      // Squash the wrong-path word; PC_OUT holds through the bubble.
      pc_f_d  = {REDIRECT_PC[31:2], 2'b00};
      ins_d   = '0;
      valid_d = 1'b0;
      if (REDIRECT_PC[1:0] != 2'b00) err_d = 1'b1;
    end else if (!STALL) begin
      ins_d    = fetch_word;
      pc_out_d = pc_f_q;
      valid_d  = 1'b1;
      pc_f_d   = pc_f_q + 32'd4;
      cnt_d    = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_f_q   <= RESET_PC;
      ins_q    <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_f_q   <= pc_f_d;
      ins_q    <= ins_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Ins       = ins_q;
  assign PC_OUT    = pc_out_q;
  assign PC4_OUT   = pc_out_q + 32'd4;
  assign VALID     = valid_q;
  assign ERR       = err_q;
  assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table for the program-level scenarios,
// then randomized traffic checked against a behavioural model.
module tb_inst_fetch;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST, STALL, REDIRECT, IMEM_WE;
  logic [31:0]   REDIRECT_PC, IMEM_WDATA;
  logic [AW-1:0] IMEM_WADDR;
  logic [31:0]   Ins, PC_OUT, PC4_OUT, FETCH_CNT;
  logic          VALID, ERR;

  inst_fetch #(.IMEM_AW(AW), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .IMEM_WE(IMEM_WE), .IMEM_WADDR(IMEM_WADDR),
    .IMEM_WDATA(IMEM_WDATA), .Ins(Ins), .PC_OUT(PC_OUT), .PC4_OUT(PC4_OUT),
    .VALID(VALID), .ERR(ERR), .FETCH_CNT(FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: architectural view of the stage.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_ins, m_pcout, m_cnt;
  logic        m_valid, m_err;

  task automatic model_step();
    logic [31:0] w;
    w = m_mem[(m_pc / 4) % DEPTH];
    if (IMEM_WE) m_mem[IMEM_WADDR] = IMEM_WDATA;
    if (RST) begin
      m_pc = 0; m_ins = 0; m_pcout = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (REDIRECT) begin
      m_pc    = REDIRECT_PC - (REDIRECT_PC % 4);
      m_ins   = 0;
      m_valid = 0;
      if (REDIRECT_PC % 4 != 0) m_err = 1;
    end else if (!STALL) begin
      m_ins   = w;
      m_pcout = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 4;
      m_cnt   = m_cnt + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, stall, redir, we;
    logic [31:0] rpc;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_ins, e_pc, e_cnt;
    logic        e_valid, e_err;
  } vec_t;

  function automatic vec_t mk(logic rst, logic stall, logic redir, logic [31:0] rpc,
                              logic we, logic [7:0] waddr, logic [31:0] wdata,
                              logic [31:0] e_ins, logic [31:0] e_pc, logic e_valid,
                              logic e_err, logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.e_ins = e_ins; v.e_pc = e_pc; v.e_valid = e_valid; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  localparam logic [31:0] SW  = 32'hAD4B0004;
  localparam logic [31:0] ADD = 32'h014B4820;

  vec_t tbl[24];

  initial begin
    RST = 1; STALL = 0; REDIRECT = 0; REDIRECT_PC = 0;
    IMEM_WE = 0; IMEM_WADDR = 0; IMEM_WDATA = 0;
    m_pc = 0; m_ins = 0; m_pcout = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hxxxx_xxxx;

    // Fill memory under reset with a recognisable pattern C000_00nn.
    for (int i = 0; i < DEPTH; i++) begin
      IMEM_WE = 1; IMEM_WADDR = AW'(i); IMEM_WDATA = 32'hC000_0000 | i;
      tick();
    end
    IMEM_WE = 0;

    //           rst st rd rpc           we wa  wdata         ins           pc            v  err cnt
    tbl[0]  = mk(1, 0, 0, 32'h0,        1, 0,  SW,           32'h0,        32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0,        1, 1,  ADD,          32'h0,        32'h0,        0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, 0,  0,            SW,           32'h0,        1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 0,  0,            ADD,          32'h4,        1, 0, 2);
    tbl[4]  = mk(0, 1, 0, 32'h0,        0, 0,  0,            ADD,          32'h4,        1, 0, 2);
    tbl[5]  = mk(0, 1, 0, 32'h0,        0, 0,  0,            ADD,          32'h4,        1, 0, 2);
    tbl[6]  = mk(0, 1, 0, 32'h0,        0, 0,  0,            ADD,          32'h4,        1, 0, 2);
    tbl[7]  = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'hC0000002, 32'h8,        1, 0, 3);
    tbl[8]  = mk(0, 1, 1, 32'h40,       0, 0,  0,            32'h0,        32'h8,        0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'hC0000010, 32'h40,       1, 0, 4);
    tbl[10] = mk(0, 0, 1, 32'h43,       0, 0,  0,            32'h0,        32'h40,       0, 1, 4);
    tbl[11] = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'hC0000010, 32'h40,       1, 1, 5);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'hC0000011, 32'h44,       1, 1, 6);
    tbl[13] = mk(0, 0, 1, 32'h3FC,      0, 0,  0,            32'h0,        32'h44,       0, 1, 6);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'hC00000FF, 32'h3FC,      1, 1, 7);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, 0,  0,            SW,           32'h400,      1, 1, 8);
    tbl[16] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 0,  0,            32'h0,        32'h400,      0, 1, 8);
    tbl[17] = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'hC00000FF, 32'hFFFFFFFC, 1, 1, 9);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 0,  0,            SW,           32'h0,        1, 1, 10);
    tbl[19] = mk(0, 0, 0, 32'h0,        0, 0,  0,            ADD,          32'h4,        1, 1, 11);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, 2,  32'h12345678, 32'hC0000002, 32'h8,        1, 1, 12);
    tbl[21] = mk(0, 0, 1, 32'h8,        0, 0,  0,            32'h0,        32'h8,        0, 1, 12);
    tbl[22] = mk(0, 0, 0, 32'h0,        0, 0,  0,            32'h12345678, 32'h8,        1, 1, 13);
    tbl[23] = mk(1, 1, 1, 32'h44,       0, 0,  0,            32'h0,        32'h0,        0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      RST = tbl[i].rst; STALL = tbl[i].stall; REDIRECT = tbl[i].redir;
      REDIRECT_PC = tbl[i].rpc; IMEM_WE = tbl[i].we;
      IMEM_WADDR = tbl[i].waddr; IMEM_WDATA = tbl[i].wdata;
      tick();
      chk($sformatf("vec%0d Ins", i),       Ins,         tbl[i].e_ins);
      chk($sformatf("vec%0d PC_OUT", i),    PC_OUT,      tbl[i].e_pc);
      chk($sformatf("vec%0d PC4_OUT", i),   PC4_OUT,     tbl[i].e_pc + 32'd4);
      chk($sformatf("vec%0d VALID", i),     32'(VALID),  32'(tbl[i].e_valid));
      chk($sformatf("vec%0d ERR", i),       32'(ERR),    32'(tbl[i].e_err));
      chk($sformatf("vec%0d FETCH_CNT", i), FETCH_CNT,   tbl[i].e_cnt);
    end

    // Randomized traffic against the model; redirects hit the full 32-bit
    // space so PC wrap and aliasing get exercised.
    for (int c = 0; c < 2000; c++) begin
      RST         = ($urandom_range(0, 59) == 0);
      STALL       = ($urandom_range(0, 3) == 0);
      REDIRECT    = ($urandom_range(0, 9) == 0);
      REDIRECT_PC = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 1023);
      IMEM_WE     = ($urandom_range(0, 2) == 0);
      IMEM_WADDR  = AW'($urandom);
      IMEM_WDATA  = $urandom;
      tick();
      chk("rnd Ins",       Ins,        m_ins);
      chk("rnd PC_OUT",    PC_OUT,     m_pcout);
      chk("rnd PC4_OUT",   PC4_OUT,    m_pcout + 32'd4);
      chk("rnd VALID",     32'(VALID), 32'(m_valid));
      chk("rnd ERR",       32'(ERR),   32'(m_err));
      chk("rnd FETCH_CNT", FETCH_CNT,  m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
